// File: rtl/pe_array_sequencer_pkg.sv
// Shared types for the PE-array command sequencer: FSM state encoding and the
// latched job descriptor.
package pe_types;

    // Default widths of the filter RAM read address and the per-job counters.
    // The job descriptor below is sized by these values.
    localparam int SEQ_ADDR_WIDTH  = 9;
    localparam int SEQ_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SEND   = 2'd2,
        FIN    = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_ADDR_WIDTH-1:0]  base_addr;
        logic [SEQ_COUNT_WIDTH-1:0] num_addr;
        logic [SEQ_COUNT_WIDTH-1:0] num_groups;
    } seq_job_t;

endpackage

// File: rtl/pe_array_sequencer.sv
// Compute-side command sequencer for the PE array. Accepts one job descriptor
// (base address, K feature beats per group, G groups), streams K feature beats
// per group with filter read addresses base..base+K-1 (mod 2^ADDR_WIDTH),
// then emits SEND_BEATS send_output beats per group, and pulses done at the end.
// All PE-side controls are registered: they appear one cycle after the
// handshake or state that causes them.
// The descriptor is held in a pe_types::seq_job_t, so ADDR_WIDTH and
// COUNT_WIDTH are expected to match the package widths.
module pe_array_sequencer
    import pe_types::*;
#(
    parameter int ADDR_WIDTH  = SEQ_ADDR_WIDTH,
    parameter int COUNT_WIDTH = SEQ_COUNT_WIDTH,
    parameter int SEND_BEATS  = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_num_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_num_groups,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    output logic                   pe_ivalid,
    output logic                   pe_feature_valid,
    output logic [ADDR_WIDTH-1:0]  pe_filter_read_addr,
    output logic                   pe_flush_accumulator,
    output logic                   pe_send_output,
    output logic                   busy,
    output logic                   done
);

    localparam int SEND_W = (SEND_BEATS > 1) ? $clog2(SEND_BEATS) : 1;

    seq_state_e             r_state, w_state_nxt;
    seq_job_t               r_job, w_job_nxt;
    logic [COUNT_WIDTH-1:0] r_beat, w_beat_nxt;
    logic [COUNT_WIDTH-1:0] r_group, w_group_nxt;
    logic [SEND_W-1:0]      r_send, w_send_nxt;

    logic                   r_ivalid, w_ivalid_nxt;
    logic                   r_fvalid, w_fvalid_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_nxt;
    logic                   r_flush, w_flush_nxt;
    logic                   r_sendo, w_sendo_nxt;
    logic                   r_done, w_done_nxt;

    logic [ADDR_WIDTH-1:0]  w_base;
    logic [COUNT_WIDTH-1:0] w_num_addr;
    logic [COUNT_WIDTH-1:0] w_num_groups;
    logic [ADDR_WIDTH-1:0]  w_beat_addr;
    logic                   w_last_beat;
    logic                   w_last_group;
    logic                   w_last_send;
    logic                   w_empty_job;

    // Address is base + beat index; the cast folds the counter into the
    // address width so the sum wraps modulo 2^ADDR_WIDTH.
    assign w_base       = ADDR_WIDTH'(r_job.base_addr);
    assign w_num_addr   = COUNT_WIDTH'(r_job.num_addr);
    assign w_num_groups = COUNT_WIDTH'(r_job.num_groups);
    assign w_beat_addr  = w_base + ADDR_WIDTH'(r_beat);
    assign w_last_beat  = (r_beat == w_num_addr - COUNT_WIDTH'(1));
    assign w_last_group = (r_group == w_num_groups - COUNT_WIDTH'(1));
    assign w_last_send  = (r_send == SEND_W'(SEND_BEATS - 1));
    assign w_empty_job  = (cfg_num_addr == '0) || (cfg_num_groups == '0);

    assign cfg_ready            = (r_state == IDLE);
    assign feat_ready           = (r_state == STREAM);
    assign busy                 = (r_state != IDLE);
    assign pe_ivalid            = r_ivalid;
    assign pe_feature_valid     = r_fvalid;
    assign pe_filter_read_addr  = r_addr;
    assign pe_flush_accumulator = r_flush;
    assign pe_send_output       = r_sendo;
    assign done                 = r_done;

    // Next-state, counter and PE-control decode; controls default to idle and
    // the read address holds so only pe_ivalid qualifies the bus.
    always_comb begin
        w_state_nxt  = r_state;
        w_job_nxt    = r_job;
        w_beat_nxt   = r_beat;
        w_group_nxt  = r_group;
        w_send_nxt   = r_send;
        w_ivalid_nxt = 1'b0;
        w_fvalid_nxt = 1'b0;
        w_addr_nxt   = r_addr;
        w_flush_nxt  = 1'b0;
        w_sendo_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_job_nxt.base_addr  = SEQ_ADDR_WIDTH'(cfg_base_addr);
                    w_job_nxt.num_addr   = SEQ_COUNT_WIDTH'(cfg_num_addr);
                    w_job_nxt.num_groups = SEQ_COUNT_WIDTH'(cfg_num_groups);
                    w_beat_nxt           = '0;
                    w_group_nxt          = '0;
                    w_send_nxt           = '0;
                    w_state_nxt          = w_empty_job ? FIN : STREAM;
                end
            end
            STREAM: begin
                if (feat_valid) begin
                    w_ivalid_nxt = 1'b1;
                    w_fvalid_nxt = 1'b1;
                    w_addr_nxt   = w_beat_addr;
                    w_flush_nxt  = (r_beat == '0);
                    if (w_last_beat) begin
                        w_beat_nxt  = '0;
                        w_send_nxt  = '0;
                        w_state_nxt = SEND;
                    end else begin
                        w_beat_nxt = r_beat + COUNT_WIDTH'(1);
                    end
                end
            end
            SEND: begin
                w_ivalid_nxt = 1'b1;
                w_sendo_nxt  = 1'b1;
                if (w_last_send) begin
                    w_send_nxt  = '0;
                    w_group_nxt = r_group + COUNT_WIDTH'(1);
                    w_state_nxt = w_last_group ? FIN : STREAM;
                end else begin
                    w_send_nxt = r_send + SEND_W'(1);
                end
            end
            FIN: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered PE controls; async reset discards the job.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_job    <= '0;
            r_beat   <= '0;
            r_group  <= '0;
            r_send   <= '0;
            r_ivalid <= 1'b0;
            r_fvalid <= 1'b0;
            r_addr   <= '0;
            r_flush  <= 1'b0;
            r_sendo  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_job    <= w_job_nxt;
            r_beat   <= w_beat_nxt;
            r_group  <= w_group_nxt;
            r_send   <= w_send_nxt;
            r_ivalid <= w_ivalid_nxt;
            r_fvalid <= w_fvalid_nxt;
            r_addr   <= w_addr_nxt;
            r_flush  <= w_flush_nxt;
            r_sendo  <= w_sendo_nxt;
            r_done   <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer: drives job descriptors and feature
// streams, records every pe_ivalid cycle, and compares the recorded sequence
// against the expected feature/flush/address/send ordering of each job.
module tb_pe_array_sequencer;

    localparam int AW = 9;
    localparam int CW = 16;
    localparam int SB = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [CW-1:0] cfg_num_addr = '0;
    logic [CW-1:0] cfg_num_groups = '0;
    logic          feat_valid = 1'b0;
    logic          feat_ready;
    logic          pe_ivalid;
    logic          pe_feature_valid;
    logic [AW-1:0] pe_filter_read_addr;
    logic          pe_flush_accumulator;
    logic          pe_send_output;
    logic          busy;
    logic          done;

    int n_err = 0;
    int n_chk = 0;

    // Recorded pe_ivalid cycles of the current job.
    logic          ev_fv [64];
    logic          ev_fl [64];
    logic          ev_sd [64];
    logic [AW-1:0] ev_ad [64];
    int            ev_cyc[64];
    int            n_ev;

    pe_array_sequencer #(
        .ADDR_WIDTH (AW),
        .COUNT_WIDTH(CW),
        .SEND_BEATS (SB)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_num_addr        (cfg_num_addr),
        .cfg_num_groups      (cfg_num_groups),
        .feat_valid          (feat_valid),
        .feat_ready          (feat_ready),
        .pe_ivalid           (pe_ivalid),
        .pe_feature_valid    (pe_feature_valid),
        .pe_filter_read_addr (pe_filter_read_addr),
        .pe_flush_accumulator(pe_flush_accumulator),
        .pe_send_output      (pe_send_output),
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".pe_ivalid"}, 32'(pe_ivalid), 32'd0);
        chk({tag, ".pe_fv"}, 32'(pe_feature_valid), 32'd0);
        chk({tag, ".pe_addr"}, 32'(pe_filter_read_addr), 32'd0);
        chk({tag, ".pe_flush"}, 32'(pe_flush_accumulator), 32'd0);
        chk({tag, ".pe_send"}, 32'(pe_send_output), 32'd0);
    endtask

    // Runs one job from descriptor to done and checks the recorded PE sequence.
    task automatic run_job(input string name, input logic [AW-1:0] base,
                           input int k, input int g, input bit toggle);
        int  cyc;
        int  done_cyc;
        int  n_bubble;
        int  idx;
        int  nfv;
        int  nsd;
        int  exp_n;
        bit  fin;
        bit  hs_prev;
        logic [AW-1:0] ea;

        @(negedge clock);
        chk({name, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
        cfg_valid      = 1'b1;
        cfg_base_addr  = base;
        cfg_num_addr   = CW'(k);
        cfg_num_groups = CW'(g);
        feat_valid     = 1'b1;
        hs_prev        = feat_valid && feat_ready;
        n_ev = 0; cyc = 0; done_cyc = -1; n_bubble = 0; fin = 1'b0;

        while (!fin && cyc < 400) begin
            @(negedge clock);
            cyc++;
            cfg_valid = 1'b0;
            if (cyc == 1) chk({name, ".busy"}, 32'(busy), 32'd1);
            chk({name, ".hs_to_fv"}, 32'(pe_feature_valid), 32'(hs_prev));
            if (pe_ivalid === 1'b1) begin
                if (n_ev < 64) begin
                    ev_fv[n_ev]  = pe_feature_valid;
                    ev_fl[n_ev]  = pe_flush_accumulator;
                    ev_sd[n_ev]  = pe_send_output;
                    ev_ad[n_ev]  = pe_filter_read_addr;
                    ev_cyc[n_ev] = cyc;
                end
                n_ev++;
            end else begin
                chk({name, ".unqualified"},
                    32'({pe_feature_valid, pe_flush_accumulator, pe_send_output}), 32'd0);
                if (n_ev > 0 && done_cyc < 0) n_bubble++;
            end
            if (done_cyc >= 0) begin
                fin = 1'b1;
                chk({name, ".done_one_cycle"}, 32'(done), 32'd0);
                chk({name, ".end_busy"}, 32'(busy), 32'd0);
                chk({name, ".end_cfg_ready"}, 32'(cfg_ready), 32'd1);
            end else if (done === 1'b1) begin
                done_cyc = cyc;
                chk({name, ".busy_at_done"}, 32'(busy), 32'd0);
            end
            feat_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            hs_prev    = feat_valid && feat_ready;
        end
        feat_valid = 1'b0;
        chk({name, ".done_seen"}, 32'(fin), 32'd1);

        exp_n = (k == 0 || g == 0) ? 0 : g * (k + SB);
        chk({name, ".n_ivalid"}, 32'(n_ev), 32'(exp_n));

        idx = 0; nfv = 0; nsd = 0;
        for (int j = 0; j < n_ev && j < 64; j++) begin
            nfv += int'(ev_fv[j]);
            nsd += int'(ev_sd[j]);
        end
        chk({name, ".count_fv"}, 32'(nfv), 32'(k * g));
        chk({name, ".count_send"}, 32'(nsd), 32'((k == 0) ? 0 : g * SB));

        if (exp_n > 0 && n_ev == exp_n) begin
            for (int gi = 0; gi < g; gi++) begin
                for (int b = 0; b < k; b++) begin
                    ea = base + AW'(b);
                    chk({name, ".feat.fv"}, 32'(ev_fv[idx]), 32'd1);
                    chk({name, ".feat.flush"}, 32'(ev_fl[idx]), 32'(b == 0));
                    chk({name, ".feat.send"}, 32'(ev_sd[idx]), 32'd0);
                    chk({name, ".feat.addr"}, 32'(ev_ad[idx]), 32'(ea));
                    idx++;
                end
                for (int s = 0; s < SB; s++) begin
                    chk({name, ".send.send"}, 32'(ev_sd[idx]), 32'd1);
                    chk({name, ".send.fv"}, 32'(ev_fv[idx]), 32'd0);
                    chk({name, ".send.flush"}, 32'(ev_fl[idx]), 32'd0);
                    idx++;
                end
            end
            chk({name, ".done_after_last_send"}, 32'(done_cyc), 32'(ev_cyc[n_ev-1] + 1));
            if (!toggle)
                chk({name, ".contiguous"}, 32'(ev_cyc[n_ev-1] - ev_cyc[0]), 32'(n_ev - 1));
            else
                chk({name, ".bubbles"}, 32'(n_bubble > 0), 32'd1);
        end
    endtask

    initial begin
        // Reset state while resetn is held low.
        repeat (2) @(negedge clock);
        chk_idle_outputs("reset");
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.feat_ready", 32'(feat_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk_idle_outputs("post_reset");

        // Basic job: addresses 0x010..0x013, flush on first beat, 4 sends.
        run_job("basic", 9'h010, 4, 1, 1'b0);

        // Address wrap through 0x1FF -> 0x000.
        run_job("wrap", 9'h1FE, 4, 1, 1'b0);

        // Two groups with feature bubbles.
        run_job("bubble", 9'h020, 3, 2, 1'b1);

        // Degenerate descriptors: accepted, done pulse, no PE activity.
        run_job("k0", 9'h033, 0, 2, 1'b0);
        run_job("g0", 9'h044, 2, 0, 1'b0);

        // Single-beat groups: every feature beat flushes.
        run_job("k1g3", 9'h005, 1, 3, 1'b0);

        // Asynchronous reset in the middle of streaming.
        @(negedge clock);
        cfg_valid      = 1'b1;
        cfg_base_addr  = 9'h100;
        cfg_num_addr   = CW'(8);
        cfg_num_groups = CW'(1);
        feat_valid     = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrst.streaming_fv", 32'(pe_feature_valid), 32'd1);
        chk("midrst.streaming_addr", 32'(pe_filter_read_addr), 32'h102);
        #2 resetn = 1'b0;
        #1 chk_idle_outputs("midrst.async");
        @(posedge clock);
        #1 chk_idle_outputs("midrst.edge");
        @(negedge clock);
        feat_valid = 1'b0;
        resetn     = 1'b1;
        @(negedge clock);
        chk_idle_outputs("midrst.release");

        // Fresh job after the discarded one.
        run_job("recover", 9'h0F0, 2, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
